// File: rtl/wb_merge_stage.sv
// Writeback stage fed by the registered ALU result. Writes the 8x8 internal
// register file, either as a full byte or rotated/merged into a bit field,
// or hands the result to the I/O bus as a request/acknowledge write. A merge
// into an I/O port is done as read, then merge, then write. Also provides the
// bypassed register read port that supplies ALU operands.
module wb_merge_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  logic       i_wb_valid,
  input  logic [7:0] i_wb_data,
  input  logic [3:0] i_wb_dst,
  input  logic       i_wb_merge,
  input  logic [2:0] i_wb_pos,
  input  logic [2:0] i_wb_len,
  input  logic [2:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_busy,
  output logic [2:0] o_io_addr,
  output logic       o_io_rd_req,
  input  logic       i_io_rd_ack,
  input  logic [7:0] i_io_rd_data,
  output logic       o_io_wr_req,
  output logic [7:0] o_io_wr_data,
  input  logic       i_io_wr_ack,
  output logic       o_io_err,
  input  logic       i_err_clr
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  // Rotate left by 0-7. When s is 0, the right shift by 8 contributes nothing.
  function automatic logic [7:0] rol8(input logic [7:0] x, input logic [2:0] s);
    return (x << s) | (x >> (4'd8 - {1'b0, s}));
  endfunction

  // Rotate the data into place and keep the old bits outside the field mask.
  // A field that runs past bit 7 wraps around to bit 0.
  function automatic logic [7:0] mergeByte(input logic [7:0] data, input logic [7:0] old,
                                           input logic [2:0] pos, input logic [2:0] len);
    logic [7:0] mask;
    mask = rol8(8'hFF >> (3'd7 - len), pos);
    return (rol8(data, pos) & mask) | (old & ~mask);
  endfunction

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [7:0]       r_regs [8];
  logic [2:0]       r_addr;
  logic [2:0]       r_pos;
  logic [2:0]       r_len;
  logic [7:0]       r_data;
  logic             r_rdReq;
  logic             r_wrReq;
  logic [7:0]       r_wrData;
  logic             r_err;
  logic             w_rdReqNext;
  logic             w_wrReqNext;
  logic [7:0]       w_wrDataNext;
  logic             w_timeout;
  logic             w_latch;
  logic             w_accept;
  logic             w_intWrite;
  logic [7:0]       w_intResult;

  // Work out acceptance and the value an internal write would store.
  // An internal write completes in one cycle and never enters the FSM.
  always_comb begin
    w_accept    = i_wb_valid & ~i_flush & (r_state == IDLE);
    w_intWrite  = w_accept & ~i_wb_dst[3];
    w_intResult = i_wb_merge ? mergeByte(i_wb_data, r_regs[i_wb_dst[2:0]], i_wb_pos, i_wb_len)
                             : i_wb_data;
  end

  // Read the operand, bypassing an internal write to the same register this cycle.
  always_comb begin
    o_rd_data = r_regs[i_rd_addr];
    if (w_intWrite && (i_wb_dst[2:0] == i_rd_addr)) begin
      o_rd_data = w_intResult;
    end
  end

  // Update the register file on the edge that accepts an internal write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (w_intWrite) begin
      r_regs[i_wb_dst[2:0]] <= w_intResult;
    end
  end

  // Next state for the I/O handshake. Each wait state restarts the counter
  // when entered, and a missing ack drops the request without writing.
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_rdReqNext  = r_rdReq;
    w_wrReqNext  = r_wrReq;
    w_wrDataNext = r_wrData;
    w_timeout    = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && i_wb_dst[3]) begin
          w_latch   = 1'b1;
          w_cntNext = '0;
          if (i_wb_merge) begin
            w_stateNext = RD_WAIT;
            w_rdReqNext = 1'b1;
          end else begin
            w_stateNext  = WR_WAIT;
            w_wrReqNext  = 1'b1;
            w_wrDataNext = i_wb_data;
          end
        end
      end
      RD_WAIT: begin
        if (i_io_rd_ack) begin
          w_wrDataNext = mergeByte(r_data, i_io_rd_data, r_pos, r_len);
          w_rdReqNext  = 1'b0;
          w_wrReqNext  = 1'b1;
          w_cntNext    = '0;
          w_stateNext  = WR_WAIT;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_rdReqNext = 1'b0;
          w_timeout   = 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      WR_WAIT: begin
        if (i_io_wr_ack) begin
          w_wrReqNext = 1'b0;
          w_stateNext = IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_wrReqNext = 1'b0;
          w_timeout   = 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_rdReqNext = 1'b0;
        w_wrReqNext = 1'b0;
      end
    endcase
  end

  // Register the FSM, the captured I/O operation and the sticky error flag.
  // If a timeout and err_clr arrive together, the timeout wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= 3'd0;
      r_pos    <= 3'd0;
      r_len    <= 3'd0;
      r_data   <= 8'h00;
      r_rdReq  <= 1'b0;
      r_wrReq  <= 1'b0;
      r_wrData <= 8'h00;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_rdReq  <= w_rdReqNext;
      r_wrReq  <= w_wrReqNext;
      r_wrData <= w_wrDataNext;
      if (w_latch) begin
        r_addr <= i_wb_dst[2:0];
        r_pos  <= i_wb_pos;
        r_len  <= i_wb_len;
        r_data <= i_wb_data;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_io_addr    = r_addr;
  assign o_io_rd_req  = r_rdReq;
  assign o_io_wr_req  = r_wrReq;
  assign o_io_wr_data = r_wrData;
  assign o_io_err     = r_err;

endmodule
